// File: rtl/vmx_pe_simd_db_if.sv
// Chain link bundle for the VMX SIMD processing element.
// The slave modport is the PE side: it consumes the upstream beat and drives the downstream beat.
// The master modport is the neighbour or bench side of the same bundle.
interface vmx_pe_simd_db_if #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 2 * DATA_W,
  parameter int IDX_W  = 7
);
  logic              in_valid;
  logic              simd_mode;
  logic              load_valid;
  logic [IDX_W-1:0]  load_idx;
  logic              weight_swap;
  logic [DATA_W-1:0] data;
  logic [ACC_W-1:0]  sum_in;

  logic              out_valid;
  logic              simd_mode_pass;
  logic              load_valid_pass;
  logic [IDX_W-1:0]  load_idx_pass;
  logic              swap_pass;
  logic [DATA_W-1:0] data_pass;
  logic [ACC_W-1:0]  sum_out;
  logic              sat_flag;

  modport slave (
    input  in_valid, simd_mode, load_valid, load_idx, weight_swap, data, sum_in,
    output out_valid, simd_mode_pass, load_valid_pass, load_idx_pass, swap_pass,
           data_pass, sum_out, sat_flag
  );

  modport master (
    output in_valid, simd_mode, load_valid, load_idx, weight_swap, data, sum_in,
    input  out_valid, simd_mode_pass, load_valid_pass, load_idx_pass, swap_pass,
           data_pass, sum_out, sat_flag
  );
endinterface

// File: rtl/vmx_pe_simd_db.sv
// VMX systolic-array processing element: signed MAC with LANES SIMD sub-lanes and
// double-buffered (shadow/active) weights. One beat per cycle, no backpressure.
// Optional feature macro: VMX_PE_SAT_EN -- saturating accumulate and sat_flag reporting;
// when undefined the accumulate wraps and sat_flag stays 0.
module vmx_pe_simd_db #(
  parameter int DATA_W = 16,
  parameter int LANES  = 2,
  parameter int ACC_W  = 2 * DATA_W,
  parameter int IDX_W  = 7
) (
  input logic              clk,
  input logic              rst,
  vmx_pe_simd_db_if.slave  pe
);

  localparam int LW  = DATA_W / LANES;
  localparam int LAW = ACC_W / LANES;

  logic signed [DATA_W-1:0]   shadow_w;
  logic signed [DATA_W-1:0]   active_w;

  logic signed [2*DATA_W-1:0] full_p;
  logic signed [ACC_W:0]      full_s;
  logic signed [LW-1:0]       d_l;
  logic signed [LW-1:0]       w_l;
  logic signed [2*LW-1:0]     p_l;
  logic signed [LAW:0]        s_l;
  logic        [ACC_W-1:0]    full_sum_p0;
  logic        [ACC_W-1:0]    lane_sum_p0;
  logic                       full_ovf_p0;
  logic                       lane_ovf_p0;

  // Clamp a one-bit-wide full-width sum to ACC_W (saturate or wrap).
  function automatic logic [ACC_W-1:0] fit_full(input logic signed [ACC_W:0] s);
`ifdef VMX_PE_SAT_EN
    if (s[ACC_W] != s[ACC_W-1])
      return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
`endif
    return s[ACC_W-1:0];
  endfunction

  // Clamp a one-bit-wide lane sum to LAW (saturate or wrap).
  function automatic logic [LAW-1:0] fit_lane(input logic signed [LAW:0] s);
`ifdef VMX_PE_SAT_EN
    if (s[LAW] != s[LAW-1])
      return s[LAW] ? {1'b1, {(LAW-1){1'b0}}} : {1'b0, {(LAW-1){1'b1}}};
`endif
    return s[LAW-1:0];
  endfunction

  // MAC datapath: full-width product/sum and per-lane products/sums, each with one guard bit
  // so overflow is visible; each lane has its own adder so no carry crosses a lane.
  always_comb begin
    full_p      = $signed(pe.data) * active_w;
    full_s      = {{(ACC_W + 1 - 2*DATA_W){full_p[2*DATA_W-1]}}, full_p}
                + {pe.sum_in[ACC_W-1], pe.sum_in};
    full_sum_p0 = fit_full(full_s);
    full_ovf_p0 = full_s[ACC_W] ^ full_s[ACC_W-1];
    lane_sum_p0 = '0;
    lane_ovf_p0 = 1'b0;
    d_l         = '0;
    w_l         = '0;
    p_l         = '0;
    s_l         = '0;
    for (int i = 0; i < LANES; i++) begin
      d_l = pe.data[i*LW +: LW];
      w_l = active_w[i*LW +: LW];
      p_l = d_l * w_l;
      s_l = {{(LAW + 1 - 2*LW){p_l[2*LW-1]}}, p_l}
          + {pe.sum_in[i*LAW + LAW - 1], pe.sum_in[i*LAW +: LAW]};
      lane_sum_p0[i*LAW +: LAW] = fit_lane(s_l);
      lane_ovf_p0 = lane_ovf_p0 | (s_l[LAW] ^ s_l[LAW-1]);
    end
  end

  // Stage p0 -> outputs: pass-through, token forwarding, weight double-buffer, MAC result.
  always_ff @(posedge clk) begin
    if (rst) begin
      pe.out_valid       <= 1'b0;
      pe.simd_mode_pass  <= 1'b0;
      pe.swap_pass       <= 1'b0;
      pe.data_pass       <= '0;
      pe.load_valid_pass <= 1'b0;
      pe.load_idx_pass   <= '0;
      pe.sum_out         <= '0;
      pe.sat_flag        <= 1'b0;
      shadow_w           <= '0;
      active_w           <= '0;
    end else begin
      pe.out_valid      <= pe.in_valid;
      pe.simd_mode_pass <= pe.simd_mode;
      pe.swap_pass      <= pe.weight_swap;
      pe.data_pass      <= pe.data;

      if (pe.load_valid && pe.load_idx == '0) begin
        shadow_w           <= $signed(pe.data);
        pe.load_valid_pass <= 1'b0;
        pe.load_idx_pass   <= '0;
      end else if (pe.load_valid) begin
        pe.load_valid_pass <= 1'b1;
        pe.load_idx_pass   <= pe.load_idx - 1'b1;
      end else begin
        pe.load_valid_pass <= 1'b0;
        pe.load_idx_pass   <= '0;
      end

      // Swap reads the pre-edge shadow, so a same-cycle capture lands only in shadow.
      if (pe.weight_swap)
        active_w <= shadow_w;

      if (pe.in_valid) begin
        pe.sum_out <= pe.simd_mode ? lane_sum_p0 : full_sum_p0;
`ifdef VMX_PE_SAT_EN
        pe.sat_flag <= pe.simd_mode ? lane_ovf_p0 : full_ovf_p0;
`else
        pe.sat_flag <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_vmx_pe_simd_db.sv
// Directed bench for vmx_pe_simd_db (DATA_W=16, LANES=2, ACC_W=32, IDX_W=7).
// Each step pushes hand-computed expected outputs; a monitor pops and compares after the edge.
module tb_vmx_pe_simd_db;

  typedef struct packed {
    logic        ov;
    logic        smp;
    logic        lvp;
    logic [6:0]  lip;
    logic        sp;
    logic [15:0] dp;
    logic [31:0] so;
    logic        sf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  bit   drive_done = 1'b0;

  exp_t  exp_q[$];
  string name_q[$];
  int    due_q[$];

  vmx_pe_simd_db_if #(.DATA_W(16), .ACC_W(32), .IDX_W(7)) bus ();

  vmx_pe_simd_db #(.DATA_W(16), .LANES(2), .ACC_W(32), .IDX_W(7)) dut (
    .clk (clk),
    .rst (rst),
    .pe  (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t mk(input logic ov, input logic smp, input logic lvp,
                              input logic [6:0] lip, input logic sp, input logic [15:0] dp,
                              input logic [31:0] so, input logic sf);
    exp_t e;
    e.ov = ov; e.smp = smp; e.lvp = lvp; e.lip = lip;
    e.sp = sp; e.dp = dp; e.so = so; e.sf = sf;
    return e;
  endfunction

  task automatic step(input string nm, input logic r, input logic iv, input logic sm,
                      input logic lv, input logic [6:0] li, input logic sw,
                      input logic [15:0] d, input logic [31:0] si, input exp_t e);
    @(posedge clk);
    #1;
    rst             = r;
    bus.in_valid    = iv;
    bus.simd_mode   = sm;
    bus.load_valid  = lv;
    bus.load_idx    = li;
    bus.weight_swap = sw;
    bus.data        = d;
    bus.sum_in      = si;
    exp_q.push_back(e);
    name_q.push_back(nm);
    due_q.push_back(cyc + 1);
  endtask

  // Monitor: compare every due expectation half a cycle after the capturing edge.
  always @(negedge clk) begin
    exp_t  act;
    exp_t  e;
    string nm;
    while (due_q.size() > 0 && due_q[0] <= cyc) begin
      void'(due_q.pop_front());
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      act.ov  = bus.out_valid;
      act.smp = bus.simd_mode_pass;
      act.lvp = bus.load_valid_pass;
      act.lip = bus.load_idx_pass;
      act.sp  = bus.swap_pass;
      act.dp  = bus.data_pass;
      act.so  = bus.sum_out;
      act.sf  = bus.sat_flag;
      n_tests++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL %s: got ov=%b smp=%b lvp=%b lip=%0d sp=%b dp=%h so=%h sf=%b, want ov=%b smp=%b lvp=%b lip=%0d sp=%b dp=%h so=%h sf=%b",
                 nm, act.ov, act.smp, act.lvp, act.lip, act.sp, act.dp, act.so, act.sf,
                 e.ov, e.smp, e.lvp, e.lip, e.sp, e.dp, e.so, e.sf);
      end
    end
  end

`ifdef VMX_PE_SAT_EN
  localparam logic [31:0] SO_POS_LANE = 32'h0000_7FFF;
  localparam logic [31:0] SO_NEG_LANE = 32'h0000_8000;
  localparam logic [31:0] SO_POS_FULL = 32'h7FFF_FFFF;
  localparam logic        SF_OVF      = 1'b1;
`else
  localparam logic [31:0] SO_POS_LANE = 32'h0000_BF00;
  localparam logic [31:0] SO_NEG_LANE = 32'h0000_40FF;
  localparam logic [31:0] SO_POS_FULL = 32'h8000_00FD;
  localparam logic        SF_OVF      = 1'b0;
`endif

  initial begin
    bus.in_valid    = 1'b0;
    bus.simd_mode   = 1'b0;
    bus.load_valid  = 1'b0;
    bus.load_idx    = '0;
    bus.weight_swap = 1'b0;
    bus.data        = '0;
    bus.sum_in      = '0;

    //       name            rst iv sm lv li sw data      sum_in         ov smp lvp lip sp dp        so            sf
    step("reset",            1, 0, 0, 0, 0, 0, 16'h0000, 32'h0,        mk(0, 0, 0, 0, 0, 16'h0000, 32'h0,        0));
    step("token_fwd",        0, 0, 0, 1, 2, 0, 16'hAAAA, 32'h0,        mk(0, 0, 1, 1, 0, 16'hAAAA, 32'h0,        0));
    step("token_capture",    0, 0, 0, 1, 0, 0, 16'h0405, 32'h0,        mk(0, 0, 0, 0, 0, 16'h0405, 32'h0,        0));
    step("mac_before_swap",  0, 1, 0, 0, 0, 0, 16'h0302, 32'h0,        mk(1, 0, 0, 0, 0, 16'h0302, 32'h0,        0));
    step("swap",             0, 0, 0, 0, 0, 1, 16'h0000, 32'h0,        mk(0, 0, 0, 0, 1, 16'h0000, 32'h0,        0));
    step("mac_full",         0, 1, 0, 0, 0, 0, 16'h0302, 32'h0,        mk(1, 0, 0, 0, 0, 16'h0302, 32'h000C170A, 0));
    step("mac_simd",         0, 1, 1, 0, 0, 0, 16'h0302, 32'h0,        mk(1, 1, 0, 0, 0, 16'h0302, 32'h000C000A, 0));
    step("mac_simd_neg",     0, 1, 1, 0, 0, 0, 16'h03FF, 32'h00000003, mk(1, 1, 0, 0, 0, 16'h03FF, 32'h000CFFFE, 0));
    step("load_0102",        0, 0, 0, 1, 0, 0, 16'h0102, 32'h0,        mk(0, 0, 0, 0, 0, 16'h0102, 32'h000CFFFE, 0));
    step("capture_and_swap", 0, 0, 0, 1, 0, 1, 16'h1111, 32'h0,        mk(0, 0, 0, 0, 1, 16'h1111, 32'h000CFFFE, 0));
    step("active_old_shadow",0, 1, 0, 0, 0, 0, 16'h0001, 32'h0,        mk(1, 0, 0, 0, 0, 16'h0001, 32'h00000102, 0));
    step("swap_1111",        0, 0, 0, 0, 0, 1, 16'h0000, 32'h0,        mk(0, 0, 0, 0, 1, 16'h0000, 32'h00000102, 0));
    step("shadow_new_data",  0, 1, 0, 0, 0, 0, 16'h0002, 32'h00000005, mk(1, 0, 0, 0, 0, 16'h0002, 32'h00002227, 0));
    step("hold_1",           0, 0, 1, 0, 0, 0, 16'hBEEF, 32'h12345678, mk(0, 1, 0, 0, 0, 16'hBEEF, 32'h00002227, 0));
    step("hold_2",           0, 0, 0, 0, 0, 0, 16'h5A5A, 32'hFFFFFFFF, mk(0, 0, 0, 0, 0, 16'h5A5A, 32'h00002227, 0));
    step("load_007f",        0, 0, 0, 1, 0, 0, 16'h007F, 32'h0,        mk(0, 0, 0, 0, 0, 16'h007F, 32'h00002227, 0));
    step("swap_007f",        0, 0, 0, 0, 0, 1, 16'h0000, 32'h0,        mk(0, 0, 0, 0, 1, 16'h0000, 32'h00002227, 0));
    step("lane_pos_ovf",     0, 1, 1, 0, 0, 0, 16'h007F, 32'h00007FFF, mk(1, 1, 0, 0, 0, 16'h007F, SO_POS_LANE,  SF_OVF));
    step("lane_neg_ovf",     0, 1, 1, 0, 0, 0, 16'h0081, 32'h00008000, mk(1, 1, 0, 0, 0, 16'h0081, SO_NEG_LANE,  SF_OVF));
    step("full_pos_ovf",     0, 1, 0, 0, 0, 0, 16'h0002, 32'h7FFFFFFF, mk(1, 0, 0, 0, 0, 16'h0002, SO_POS_FULL,  SF_OVF));
    step("hold_sat_flag",    0, 0, 0, 0, 0, 0, 16'h0000, 32'h0,        mk(0, 0, 0, 0, 0, 16'h0000, SO_POS_FULL,  SF_OVF));
    step("sat_flag_clear",   0, 1, 0, 0, 0, 0, 16'h0001, 32'h0,        mk(1, 0, 0, 0, 0, 16'h0001, 32'h0000007F, 0));
    step("token_in_flight",  0, 1, 1, 1, 3, 0, 16'h1234, 32'h0,        mk(1, 1, 1, 2, 0, 16'h1234, 32'h000019CC, 0));
    step("mid_reset",        1, 1, 1, 1, 5, 1, 16'h7777, 32'h11111111, mk(0, 0, 0, 0, 0, 16'h0000, 32'h0,        0));
    step("zero_weights",     0, 1, 0, 0, 0, 0, 16'h0005, 32'h00000009, mk(1, 0, 0, 0, 0, 16'h0005, 32'h00000009, 0));
    step("idle",             0, 0, 0, 0, 0, 0, 16'h0000, 32'h0,        mk(0, 0, 0, 0, 0, 16'h0000, 32'h00000009, 0));
    drive_done = 1'b1;
  end

  // Wait (bounded) for the scoreboard to drain, then report.
  initial begin
    wait (drive_done);
    for (int i = 0; i < 20 && due_q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    if (due_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d pending, want 0 pending", due_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no summary by 100000, want finish");
    $fatal(1, "timeout");
  end

endmodule
